// File: rtl/z8_alu.sv
// z8_alu: Z8-style 8-bit ALU, registered result and flag byte (latency 1).
// Ports: clk, rst_n (sync, active-low), mode[4:0], a, b, flags -> out, outFlags.
// Optional: define Z8_ALU_DA_EN to implement decimal adjust (mode 04).
module z8_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] mode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] flags,
  output logic [7:0] out,
  output logic [7:0] outFlags
);

  localparam logic [4:0] DEC  = 5'h00;
  localparam logic [4:0] RLC  = 5'h01;
  localparam logic [4:0] INC  = 5'h02;
  localparam logic [4:0] LD   = 5'h03;
  localparam logic [4:0] DA   = 5'h04;
  localparam logic [4:0] INCW0 = 5'h05;
  localparam logic [4:0] COM  = 5'h06;
  localparam logic [4:0] DECW = 5'h08;
  localparam logic [4:0] RL   = 5'h09;
  localparam logic [4:0] INCW = 5'h0A;
  localparam logic [4:0] CLR  = 5'h0B;
  localparam logic [4:0] RRC  = 5'h0C;
  localparam logic [4:0] SRA  = 5'h0D;
  localparam logic [4:0] RR   = 5'h0E;
  localparam logic [4:0] SWAP = 5'h0F;
  localparam logic [4:0] ADD  = 5'h10;
  localparam logic [4:0] ADC  = 5'h11;
  localparam logic [4:0] SUB  = 5'h12;
  localparam logic [4:0] SBC  = 5'h13;
  localparam logic [4:0] OR_  = 5'h14;
  localparam logic [4:0] AND_ = 5'h15;
  localparam logic [4:0] TCM  = 5'h16;
  localparam logic [4:0] TM   = 5'h17;
  localparam logic [4:0] CP   = 5'h1A;
  localparam logic [4:0] XOR_ = 5'h1B;

  // flag bit positions
  localparam int FC = 7;
  localparam int FZ = 6;
  localparam int FS = 5;
  localparam int FV = 4;
  localparam int FD = 3;
  localparam int FH = 2;

  logic       cin;
  logic [8:0] sum9;
  logic [8:0] dif9;
  logic       hAdd;
  logic       hSub;
  logic       vAdd;
  logic       vSub;
  logic [7:0] res;
  logic [7:0] nf;

`ifdef Z8_ALU_DA_EN
  logic       lowAdj;
  logic       highAdj;
  logic [8:0] daLo;
  logic [8:0] daHi;
  logic [7:0] daSub;
`endif

  assign cin  = (mode == ADC || mode == SBC) ? flags[FC] : 1'b0;
  assign sum9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  assign dif9 = {1'b0, a} - {1'b0, b} - {8'd0, cin};
  // carry/borrow across the nibble boundary recovered from bit 4
  assign hAdd = a[4] ^ b[4] ^ sum9[4];
  assign hSub = a[4] ^ b[4] ^ dif9[4];
  assign vAdd = (a[7] == b[7]) && (sum9[7] != a[7]);
  assign vSub = (a[7] != b[7]) && (dif9[7] != a[7]);

`ifdef Z8_ALU_DA_EN
  always_comb begin
    lowAdj  = flags[FH] || (a[3:0] > 4'd9);
    daLo    = {1'b0, a} + (lowAdj ? 9'h006 : 9'h000);
    highAdj = flags[FC] || daLo[8] || (daLo[7:4] > 4'd9);
    daHi    = daLo + (highAdj ? 9'h060 : 9'h000);
    daSub   = a - (flags[FH] ? 8'h06 : 8'h00)
                - (flags[FC] ? 8'h60 : 8'h00);
  end
`endif

  always_comb begin
    res = a;
    nf  = flags;
    unique case (mode)
      ADD, ADC: begin
        res    = sum9[7:0];
        nf[FC] = sum9[8];
        nf[FV] = vAdd;
        nf[FH] = hAdd;
        nf[FD] = 1'b0;
      end
      SUB, SBC, CP: begin
        res    = dif9[7:0];
        nf[FC] = dif9[8];
        nf[FV] = vSub;
        if (mode != CP) begin
          nf[FH] = hSub;
          nf[FD] = 1'b1;
        end
      end
      OR_, AND_, XOR_, TCM, TM: begin
        unique case (mode)
          OR_:     res = a | b;
          AND_:    res = a & b;
          XOR_:    res = a ^ b;
          TCM:     res = ~a & b;
          default: res = a & b;
        endcase
        nf[FV] = 1'b0;
      end
      DEC, DECW: begin
        res    = a - 8'h01;
        nf[FV] = (a == 8'h80);
      end
      INC, INCW: begin
        res    = a + 8'h01;
        nf[FV] = (a == 8'h7F);
      end
      RLC: begin
        res    = {a[6:0], flags[FC]};
        nf[FC] = a[7];
        nf[FV] = res[7] ^ a[7];
      end
      RL: begin
        res    = {a[6:0], a[7]};
        nf[FC] = a[7];
        nf[FV] = res[7] ^ a[7];
      end
      RRC: begin
        res    = {flags[FC], a[7:1]};
        nf[FC] = a[0];
        nf[FV] = res[7] ^ a[7];
      end
      RR: begin
        res    = {a[0], a[7:1]};
        nf[FC] = a[0];
        nf[FV] = res[7] ^ a[7];
      end
      SRA: begin
        res    = {a[7], a[7:1]};
        nf[FC] = a[0];
        nf[FV] = 1'b0;
      end
      COM: begin
        res    = ~a;
        nf[FV] = 1'b0;
      end
      SWAP: res = {a[3:0], a[7:4]};
      CLR:  res = 8'h00;
      INCW0: nf[FV] = 1'b0;
`ifdef Z8_ALU_DA_EN
      DA: begin
        if (!flags[FD]) begin
          res = daHi[7:0];
          if (highAdj) nf[FC] = 1'b1;
        end else begin
          res = daSub;
        end
      end
`endif
      default: res = a;
    endcase

    // Z/S for every op that produces a new value
    unique case (mode)
      LD, CLR: ;
      DECW, INCW, INCW0: begin
        nf[FZ] = flags[FZ] && (res == 8'h00);
        nf[FS] = res[7];
      end
      ADD, ADC, SUB, SBC, CP, OR_, AND_, XOR_,
      TCM, TM, DEC, INC, RLC, RL, RRC, RR,
      SRA, COM, SWAP: begin
        nf[FZ] = (res == 8'h00);
        nf[FS] = res[7];
      end
`ifdef Z8_ALU_DA_EN
      DA: begin
        nf[FZ] = (res == 8'h00);
        nf[FS] = res[7];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out      <= 8'h00;
      outFlags <= 8'h00;
    end else begin
      out      <= res;
      outFlags <= nf;
    end
  end

endmodule

// File: tb/tb_z8_alu.sv
// tb_z8_alu: scoreboard bench for z8_alu.
// Directed vectors push expected {out,flags}; a monitor pops per edge.
module tb_z8_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] flags;
  logic [7:0] out;
  logic [7:0] outFlags;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ[$];
  string       nameQ[$];

  z8_alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .a(a),
    .b(b),
    .flags(flags),
    .out(out),
    .outFlags(outFlags)
  );

  always #5 clk = ~clk;

  // monitor: one result per rising edge for every issued vector
  always @(posedge clk) begin
    logic [15:0] e;
    string       n;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checks++;
      if ({out, outFlags} !== e) begin
        errors++;
        $display("FAIL %s: got out=%h flags=%h want out=%h flags=%h",
                 n, out, outFlags, e[15:8], e[7:0]);
      end
    end
  end

  task automatic issue(input logic rst, input logic [4:0] m,
                       input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] vf, input logic [7:0] eo,
                       input logic [7:0] ef, input string n);
    @(negedge clk);
    rst_n = rst;
    mode  = m;
    a     = va;
    b     = vb;
    flags = vf;
    expQ.push_back({eo, ef});
    nameQ.push_back(n);
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 5'h10;
    a     = 8'h7F;
    b     = 8'h01;
    flags = 8'hFF;
    issue(0, 5'h10, 8'h7F, 8'h01, 8'hFF, 8'h00, 8'h00, "reset1");
    issue(0, 5'h10, 8'h7F, 8'h01, 8'hFF, 8'h00, 8'h00, "reset2");
    issue(1, 5'h10, 8'h7F, 8'h01, 8'h00, 8'h80, 8'h34, "add_ovf");
    issue(1, 5'h10, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hC4, "add_carry");
    issue(1, 5'h11, 8'h12, 8'h34, 8'h80, 8'h47, 8'h00, "adc");
    issue(1, 5'h12, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hAC, "sub_borrow");
    issue(1, 5'h1A, 8'h00, 8'h01, 8'h0C, 8'hFF, 8'hAC, "cp_keep_dh");
    issue(1, 5'h1A, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hA0, "cp_dh_zero");
    issue(1, 5'h13, 8'h10, 8'h01, 8'h80, 8'h0E, 8'h0C, "sbc");
    issue(1, 5'h15, 8'hF0, 8'h0F, 8'h93, 8'h00, 8'hC3, "and_zero");
    issue(1, 5'h1B, 8'h5A, 8'hFF, 8'h0C, 8'hA5, 8'h2C, "xor");
    issue(1, 5'h16, 8'hF0, 8'hFF, 8'h00, 8'h0F, 8'h00, "tcm");
    issue(1, 5'h17, 8'h80, 8'hC0, 8'h10, 8'h80, 8'h20, "tm");
    issue(1, 5'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, "or_zero");
    issue(1, 5'h00, 8'h80, 8'h00, 8'h84, 8'h7F, 8'h94, "dec_ovf");
    issue(1, 5'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h40, "inc_wrap");
    issue(1, 5'h03, 8'h3C, 8'h00, 8'hA5, 8'h3C, 8'hA5, "ld");
    issue(1, 5'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'hD0, "rlc");
    issue(1, 5'h09, 8'h81, 8'h00, 8'h00, 8'h03, 8'h90, "rl");
    issue(1, 5'h0C, 8'h01, 8'h00, 8'h80, 8'h80, 8'hB0, "rrc");
    issue(1, 5'h0E, 8'h02, 8'h00, 8'h80, 8'h01, 8'h00, "rr");
    issue(1, 5'h0D, 8'h81, 8'h00, 8'h10, 8'hC0, 8'hA0, "sra");
    issue(1, 5'h06, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h40, "com");
    issue(1, 5'h0F, 8'h5A, 8'h00, 8'h00, 8'hA5, 8'h20, "swap");
    issue(1, 5'h0B, 8'h77, 8'h00, 8'h5A, 8'h00, 8'h5A, "clr");
    issue(1, 5'h05, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, "incw_up0");
    issue(1, 5'h0A, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, "incw_wrap");
    issue(1, 5'h0A, 8'h7F, 8'h00, 8'h40, 8'h80, 8'h30, "incw_ovf");
    issue(1, 5'h08, 8'h01, 8'h00, 8'h40, 8'h00, 8'h40, "decw_zero");
    issue(1, 5'h07, 8'h12, 8'h00, 8'h3F, 8'h12, 8'h3F, "undef07");
    issue(1, 5'h1C, 8'h34, 8'h55, 8'hC0, 8'h34, 8'hC0, "undef1C");
`ifdef Z8_ALU_DA_EN
    issue(1, 5'h10, 8'h15, 8'h27, 8'h00, 8'h3C, 8'h00, "add_bcd");
    issue(1, 5'h04, 8'h3C, 8'h00, 8'h00, 8'h42, 8'h00, "da_add");
    issue(1, 5'h04, 8'h9A, 8'h00, 8'h00, 8'h00, 8'hC0, "da_add_c");
    issue(1, 5'h04, 8'h1F, 8'h00, 8'h0C, 8'h19, 8'h0C, "da_sub");
`else
    issue(1, 5'h04, 8'h3C, 8'h00, 8'h00, 8'h3C, 8'h00, "da_off");
`endif
    issue(0, 5'h10, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, "reset_mid");
    issue(1, 5'h02, 8'h41, 8'h00, 8'h00, 8'h42, 8'h00, "after_rst");

    repeat (4) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results pending, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
